// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the D_PLL reconfiguration sequencer.
package pll_reconfig_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_C0,
        S_WR_START,
        S_POLL_RD,
        S_POLL_CHK,
        S_WAIT_LOCK,
        S_FIN
    } state_t;

    // Reconfig core management-port register map
    localparam logic [5:0] ADDR_MODE   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_START  = 6'h02;
    localparam logic [5:0] ADDR_N      = 6'h03;
    localparam logic [5:0] ADDR_M      = 6'h04;
    localparam logic [5:0] ADDR_C      = 6'h05;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_POLL = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;

    // Counter word layout: [17]=odd, [16]=bypass, [15:8]=high, [7:0]=low
    localparam int CW_WIDTH  = 18;
    localparam int CW_ODD    = 17;
    localparam int CW_BYPASS = 16;
    localparam int CW_HI_LSB = 8;
    localparam int CW_LO_LSB = 0;
    localparam int C_SEL_LSB = 18;

    localparam logic [4:0] C0_SEL = 5'd0;

    // Build a counter write word; the select field only matters for C counters.
    function automatic logic [31:0] cnt_word(input logic [CW_WIDTH-1:0] w,
                                             input logic [4:0] sel);
        return {9'b0, sel, w};
    endfunction

endpackage

// File: rtl/pll_reconfig_if.sv
// Request/status handshake and Avalon-MM management bus of the sequencer.
interface pll_reconfig_if;

    logic        req_valid;
    logic        req_ready;
    logic [17:0] req_n;
    logic [17:0] req_m;
    logic [17:0] req_c0;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    // Controller side
    modport master (
        input  req_valid, req_n, req_m, req_c0, mgmt_readdata, mgmt_waitrequest,
        output req_ready, busy, done, error, err_code,
               mgmt_address, mgmt_writedata, mgmt_write, mgmt_read
    );

    // Host / reconfig core side
    modport slave (
        output req_valid, req_n, req_m, req_c0, mgmt_readdata, mgmt_waitrequest,
        input  req_ready, busy, done, error, err_code,
               mgmt_address, mgmt_writedata, mgmt_write, mgmt_read
    );

endinterface

// File: rtl/pll_reconfig_ctrl_lock_sync.sv
// Synchroniser for the asynchronous PLL locked flag plus a 4-cycle stability
// qualifier. Both are held clear while disabled so a lock left over from
// before the reconfiguration cannot qualify immediately.
module pll_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_locked,
    input  logic i_en,
    output logic o_lock_stable
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_qual;

    // Shift locked through the sync chain and count consecutive high cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_qual <= '0;
        end else if (!i_en) begin
            r_sync <= '0;
            r_qual <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_locked};
            if (!r_sync[SYNC_STAGES-1])
                r_qual <= '0;
            else if (r_qual != 3'd4)
                r_qual <= r_qual + 3'd1;
        end
    end

    assign o_lock_stable = (r_qual == 3'd4);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// D_PLL dynamic reconfiguration sequencer.
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE        | ready for a request
// WR_MODE     | write polling mode (addr 0x00)
// WR_N        | write N counter (addr 0x03)
// WR_M        | write M counter (addr 0x04)
// WR_C0       | write C0 counter (addr 0x05)
// WR_START    | kick the reconfiguration (addr 0x02)
// POLL_RD     | read status (addr 0x01)
// POLL_CHK    | inspect status bit 0, retry or give up
// WAIT_LOCK   | wait for qualified lock or lock timeout
// FIN         | one-cycle done/error pulse
//
// Each bus state has two phases: phase 0 drives the strobe until the
// transfer completes, phase 1 is a strobe-low gap before moving on.
module pll_reconfig_ctrl
    import pll_reconfig_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 65535,
    parameter int POLL_LIMIT   = 1024,
    parameter int SYNC_STAGES  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pll_locked,
    pll_reconfig_if.master bus
);

    localparam logic [19:0] LOCK_LOAD  = 20'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] POLL_LAST  = 16'(POLL_LIMIT);

    state_t      r_state, w_next;
    logic        r_phase, w_phase;
    logic [17:0] r_n, r_m, r_c0;
    logic [1:0]  r_err, w_err;
    logic [15:0] r_poll, w_poll;
    logic [19:0] r_lock_cnt, w_lock_cnt;
    logic        r_status, w_status;
    logic        w_latch;
    logic        w_wr, w_rd;
    logic [5:0]  w_addr;
    logic [31:0] w_wdata;
    logic        w_xfer_done;
    logic        w_lock_en;
    logic        w_lock_stable;
    logic        w_unused_rd;

    assign w_unused_rd = ^bus.mgmt_readdata[31:1];
    assign w_lock_en   = (r_state == S_WAIT_LOCK);
    assign w_xfer_done = (w_wr || w_rd) && !bus.mgmt_waitrequest;

    pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_locked      (pll_locked),
        .i_en          (w_lock_en),
        .o_lock_stable (w_lock_stable)
    );

    // Bus command decode; depends only on registers so it stays stable under waitrequest
    always_comb begin
        w_wr    = 1'b0;
        w_rd    = 1'b0;
        w_addr  = ADDR_MODE;
        w_wdata = '0;
        if (!r_phase) begin
            case (r_state)
                S_WR_MODE:  begin w_wr = 1'b1; w_addr = ADDR_MODE;  w_wdata = 32'd1; end
                S_WR_N:     begin w_wr = 1'b1; w_addr = ADDR_N;     w_wdata = cnt_word(r_n, 5'd0); end
                S_WR_M:     begin w_wr = 1'b1; w_addr = ADDR_M;     w_wdata = cnt_word(r_m, 5'd0); end
                S_WR_C0:    begin w_wr = 1'b1; w_addr = ADDR_C;     w_wdata = cnt_word(r_c0, C0_SEL); end
                S_WR_START: begin w_wr = 1'b1; w_addr = ADDR_START; w_wdata = 32'd1; end
                S_POLL_RD:  begin w_rd = 1'b1; w_addr = ADDR_STATUS; end
                default: ;
            endcase
        end
    end

    // Next-state and datapath updates
    always_comb begin
        w_next     = r_state;
        w_phase    = r_phase;
        w_err      = r_err;
        w_poll     = r_poll;
        w_lock_cnt = r_lock_cnt;
        w_status   = r_status;
        w_latch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_latch = 1'b1;
                    w_err   = ERR_NONE;
                    w_poll  = '0;
                    w_phase = 1'b0;
                    w_next  = S_WR_MODE;
                end
            end
            S_WR_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_START, S_POLL_RD: begin
                if (r_phase) begin
                    w_phase = 1'b0;
                    case (r_state)
                        S_WR_MODE:  w_next = S_WR_N;
                        S_WR_N:     w_next = S_WR_M;
                        S_WR_M:     w_next = S_WR_C0;
                        S_WR_C0:    w_next = S_WR_START;
                        S_WR_START: w_next = S_POLL_RD;
                        default:    w_next = S_POLL_CHK;
                    endcase
                end else if (w_xfer_done) begin
                    w_phase = 1'b1;
                    if (r_state == S_POLL_RD)
                        w_status = bus.mgmt_readdata[0];
                end
            end
            S_POLL_CHK: begin
                if (r_status) begin
                    w_lock_cnt = LOCK_LOAD;
                    w_next     = S_WAIT_LOCK;
                end else begin
                    w_poll = r_poll + 16'd1;
                    if (w_poll == POLL_LAST) begin
                        w_err  = ERR_POLL;
                        w_next = S_FIN;
                    end else begin
                        w_next = S_POLL_RD;
                    end
                end
            end
            S_WAIT_LOCK: begin
                if (w_lock_stable) begin
                    w_next = S_FIN;
                end else if (r_lock_cnt == '0) begin
                    w_err  = ERR_LOCK;
                    w_next = S_FIN;
                end else begin
                    w_lock_cnt = r_lock_cnt - 20'd1;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_phase    <= 1'b0;
            r_n        <= '0;
            r_m        <= '0;
            r_c0       <= '0;
            r_err      <= ERR_NONE;
            r_poll     <= '0;
            r_lock_cnt <= '0;
            r_status   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_phase    <= w_phase;
            r_err      <= w_err;
            r_poll     <= w_poll;
            r_lock_cnt <= w_lock_cnt;
            r_status   <= w_status;
            if (w_latch) begin
                r_n  <= bus.req_n;
                r_m  <= bus.req_m;
                r_c0 <= bus.req_c0;
            end
        end
    end

    assign bus.req_ready      = rst_n && (r_state == S_IDLE);
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = (r_state == S_FIN) && (r_err == ERR_NONE);
    assign bus.error          = (r_state == S_FIN) && (r_err != ERR_NONE);
    assign bus.err_code       = r_err;
    assign bus.mgmt_address   = w_addr;
    assign bus.mgmt_writedata = w_wdata;
    assign bus.mgmt_write     = w_wr;
    assign bus.mgmt_read      = w_rd;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with a small Avalon-MM responder.
module tb_pll_reconfig_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic pll_locked = 1'b0;

    always #5 clk = ~clk;

    pll_reconfig_if bus();

    pll_reconfig_ctrl #(
        .LOCK_TIMEOUT (50),
        .POLL_LIMIT   (4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .bus        (bus)
    );

    // stimulus knobs (written by the initial block)
    logic status_bit  = 1'b1;
    int   wait_n      = 0;
    bit   lock_pat_en = 1'b0;
    int   on1 = 1000, off1 = 1000, on2 = 1000;
    logic lock_hold   = 1'b0;

    // responder / monitor state (written by the monitor only)
    int          cyc = 0;
    int          done_cnt = 0, err_cnt = 0, t_done = 0, t_err = 0;
    int          both_err = 0, stall_err = 0, stall_cycles = 0;
    int          log_n = 0;
    logic [5:0]  log_addr [64];
    logic [31:0] log_data [64];
    logic        log_wr   [64];
    int          wcnt = 0;
    bit          prev_wait = 1'b0;
    logic [5:0]  p_addr;
    logic [31:0] p_data;
    logic        p_wr, p_rd;
    int          lock_k = -1;

    int n_assert = 0;
    int n_fail   = 0;
    int t_acc    = 0;

    assign bus.mgmt_readdata = {31'b0, status_bit};

    always @(posedge clk) begin
        #1;
        cyc++;
        if (lock_pat_en) begin
            if (lock_k >= 0) lock_k++;
            pll_locked = (lock_k >= 0) && ((lock_k >= on1 && lock_k < off1) || lock_k >= on2);
        end else begin
            lock_k     = -1;
            pll_locked = lock_hold;
        end
        if (!rst_n) begin
            bus.mgmt_waitrequest = 1'b0;
            wcnt      = 0;
            prev_wait = 1'b0;
        end else begin
            if (bus.done)  begin done_cnt++; t_done = cyc; end
            if (bus.error) begin err_cnt++;  t_err  = cyc; end
            if (bus.mgmt_write && bus.mgmt_read) both_err++;
            if (prev_wait && (bus.mgmt_write !== p_wr || bus.mgmt_read !== p_rd ||
                              bus.mgmt_address !== p_addr || bus.mgmt_writedata !== p_data))
                stall_err++;
            if (bus.mgmt_write || bus.mgmt_read) begin
                if (bus.mgmt_write && wcnt < wait_n) begin
                    bus.mgmt_waitrequest = 1'b1;
                    wcnt++;
                    stall_cycles++;
                    prev_wait = 1'b1;
                    p_wr = bus.mgmt_write;  p_rd = bus.mgmt_read;
                    p_addr = bus.mgmt_address; p_data = bus.mgmt_writedata;
                end else begin
                    bus.mgmt_waitrequest = 1'b0;
                    wcnt      = 0;
                    prev_wait = 1'b0;
                    if (log_n < 64) begin
                        log_addr[log_n] = bus.mgmt_address;
                        log_data[log_n] = bus.mgmt_writedata;
                        log_wr[log_n]   = bus.mgmt_write;
                        log_n++;
                    end
                    if (bus.mgmt_write && bus.mgmt_address == 6'h02 && lock_pat_en) begin
                        lock_k     = 0;
                        pll_locked = 1'b0;
                    end
                end
            end else begin
                bus.mgmt_waitrequest = 1'b0;
                wcnt      = 0;
                prev_wait = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c0,
                          input bit keep_valid);
        @(negedge clk);
        bus.req_n     = n;
        bus.req_m     = m;
        bus.req_c0    = c0;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #2;
        t_acc = cyc;
        bus.req_valid = keep_valid;
        bus.req_n  = 18'($urandom);
        bus.req_m  = 18'($urandom);
        bus.req_c0 = 18'($urandom);
        check("busy_after_accept", bus.busy, 1);
        check("ready_after_accept", bus.req_ready, 0);
    endtask

    task automatic wait_fin(input int max_cyc);
        int  base;
        bit  seen;
        base = done_cnt + err_cnt;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(posedge clk);
            #2;
            if (done_cnt + err_cnt != base) seen = 1'b1;
        end
        check("fin_seen", seen, 1);
    endtask

    task automatic wait_log(input int target, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(posedge clk);
            #2;
            if (log_n >= target) seen = 1'b1;
        end
        check("log_reached", seen, 1);
    endtask

    task automatic check_seq(input int base, input logic [17:0] n, input logic [17:0] m,
                             input logic [17:0] c0);
        logic [5:0]  a;
        logic [31:0] d;
        logic        w;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       begin a = 6'h00; d = 32'd1;         w = 1'b1; end
                1:       begin a = 6'h03; d = {14'b0, n};    w = 1'b1; end
                2:       begin a = 6'h04; d = {14'b0, m};    w = 1'b1; end
                3:       begin a = 6'h05; d = {14'b0, c0};   w = 1'b1; end
                4:       begin a = 6'h02; d = 32'd1;         w = 1'b1; end
                default: begin a = 6'h01; d = 32'd0;         w = 1'b0; end
            endcase
            if (base + i < 64) begin
                check($sformatf("seq%0d_addr", i), 32'(log_addr[base+i]), 32'(a));
                check($sformatf("seq%0d_wr", i), 32'(log_wr[base+i]), 32'(w));
                if (w) check($sformatf("seq%0d_data", i), log_data[base+i], d);
            end
        end
    endtask

    initial begin
        int base, d0, e0, s0, reads;

        bus.req_valid = 1'b0;
        bus.req_n  = '0;
        bus.req_m  = '0;
        bus.req_c0 = '0;
        rst_n = 1'b0;

        // reset state
        #3;
        check("rst_ready", bus.req_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_write", bus.mgmt_write, 0);
        check("rst_read", bus.mgmt_read, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_err_code", 32'(bus.err_code), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", bus.req_ready, 1);

        // nominal: lock rises 10 cycles after start
        status_bit = 1'b1; wait_n = 0;
        on1 = 10; off1 = 1000; on2 = 1000; lock_pat_en = 1'b1;
        base = log_n; d0 = done_cnt; e0 = err_cnt;
        do_req(18'h10000, 18'h00A0A, 18'h00505, 1'b0);
        wait_fin(200);
        check("nom_log_count", log_n - base, 6);
        check_seq(base, 18'h10000, 18'h00A0A, 18'h00505);
        check("nom_done", done_cnt - d0, 1);
        check("nom_error", err_cnt - e0, 0);
        check("nom_err_code", 32'(bus.err_code), 0);
        check("nom_latency", t_done - t_acc, 25);

        // waitrequest held 3 cycles on each write, lock already high
        repeat (3) @(posedge clk);
        lock_pat_en = 1'b0; lock_hold = 1'b1; wait_n = 3;
        base = log_n; d0 = done_cnt; s0 = stall_cycles;
        do_req(18'h00303, 18'h1FFFF, 18'h3FFFF, 1'b0);
        wait_fin(300);
        check_seq(base, 18'h00303, 18'h1FFFF, 18'h3FFFF);
        check("wr_done", done_cnt - d0, 1);
        check("wr_stall_cycles", stall_cycles - s0, 15);
        check("wr_stable", stall_err, 0);
        check("wr_latency", t_done - t_acc, 35);
        wait_n = 0;

        // status never done -> poll timeout after 4 reads
        repeat (3) @(posedge clk);
        status_bit = 1'b0;
        base = log_n; d0 = done_cnt; e0 = err_cnt;
        do_req(18'h00101, 18'h00202, 18'h00303, 1'b0);
        wait_fin(300);
        reads = 0;
        for (int i = base; i < log_n && i < 64; i++) if (!log_wr[i]) reads++;
        check("poll_reads", reads, 4);
        check("poll_error", err_cnt - e0, 1);
        check("poll_done", done_cnt - d0, 0);
        check("poll_err_code", 32'(bus.err_code), 1);
        @(posedge clk);
        #2;
        check("poll_busy_after", bus.busy, 0);
        check("poll_ready_after", bus.req_ready, 1);
        check("poll_err_code_held", 32'(bus.err_code), 1);

        // locked never rises -> lock timeout 50 cycles into WAIT_LOCK
        repeat (3) @(posedge clk);
        status_bit = 1'b1; lock_hold = 1'b0;
        e0 = err_cnt;
        do_req(18'h00101, 18'h00202, 18'h00303, 1'b0);
        check("err_code_cleared", 32'(bus.err_code), 0);
        wait_fin(300);
        check("lock_error", err_cnt - e0, 1);
        check("lock_err_code", 32'(bus.err_code), 2);
        check("lock_timeout_latency", t_err - t_acc, 63);

        // locked pulses 3 cycles, drops 2, then stays high
        repeat (3) @(posedge clk);
        on1 = 10; off1 = 13; on2 = 15; lock_pat_en = 1'b1;
        d0 = done_cnt;
        do_req(18'h00404, 18'h00505, 18'h00606, 1'b0);
        check("glitch_err_code_cleared", 32'(bus.err_code), 0);
        wait_fin(300);
        check("glitch_done", done_cnt - d0, 1);
        check("glitch_latency", t_done - t_acc, 30);

        // reset during WR_M, then a fresh request with req_valid held during busy
        repeat (3) @(posedge clk);
        lock_pat_en = 1'b0; lock_hold = 1'b1;
        base = log_n; d0 = done_cnt;
        do_req(18'h00111, 18'h00222, 18'h00333, 1'b0);
        wait_log(base + 2, 50);
        repeat (2) @(posedge clk);
        #2;
        check("abort_in_wr_m_write", bus.mgmt_write, 1);
        check("abort_in_wr_m_addr", 32'(bus.mgmt_address), 4);
        rst_n = 1'b0;
        #1;
        check("abort_write", bus.mgmt_write, 0);
        check("abort_read", bus.mgmt_read, 0);
        check("abort_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready_after", bus.req_ready, 1);
        check("abort_no_done", done_cnt - d0, 0);
        base = log_n;
        do_req(18'h20A0B, 18'h00C0D, 18'h10E0F, 1'b1);
        wait_fin(200);
        bus.req_valid = 1'b0;
        check_seq(base, 18'h20A0B, 18'h00C0D, 18'h10E0F);
        check("rerun_latency", t_done - t_acc, 20);
        repeat (30) @(posedge clk);
        #2;
        check("rerun_single_done", done_cnt - d0, 1);
        check("rerun_idle", bus.busy, 0);
        check("rerun_no_extra_xfer", log_n - base, 6);

        check("never_rd_and_wr", both_err, 0);
        check("stable_under_wait", stall_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
Sequences a dynamic reconfiguration of the D_PLL output frequency. Accepts one request carrying new N, M and C0 counter words, then drives the PLL reconfiguration core over its Avalon-MM management port: mode, counters, start, status poll. Then waits for `locked` and reports done or error. Sits between the host/config register block and the reconfig core that drives `reconfig_to_pll`/`reconfig_from_pll`.

Parameters:
- LOCK_TIMEOUT, 65535, cycles allowed for `locked` to reassert after start completes (range 1..2^20-1)
- POLL_LIMIT, 1024, maximum status reads before declaring a reconfig timeout (range 1..65535)
- SYNC_STAGES, 2, flop stages synchronising the asynchronous `pll_locked` input (≥2)

Ports:
- clk  in  1  management clock (same domain as the reconfig core mgmt port)
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  reconfiguration request
- req_ready  out  1  high only in IDLE
- req_n  in  18  N counter word: [17]=odd, [16]=bypass, [15:8]=high, [7:0]=low
- req_m  in  18  M counter word, same format
- req_c0  in  18  C0 counter word, same format
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: success
- error  out  1  one-cycle pulse: failure
- err_code  out  2  0=none, 1=poll timeout, 2=lock timeout; held until next accepted request
- mgmt_address  out  6  Avalon-MM address
- mgmt_writedata  out  32  Avalon-MM write data
- mgmt_write  out  1  Avalon-MM write strobe
- mgmt_read  out  1  Avalon-MM read strobe
- mgmt_readdata  in  32  Avalon-MM read data
- mgmt_waitrequest  in  1  Avalon-MM waitrequest
- pll_locked  in  1  PLL `locked`, asynchronous to clk

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, sync chain 0. Exception: req_ready is 1 once reset has been deasserted.
- Handshake: a request is accepted when req_valid && req_ready. On acceptance:
  - req_n, req_m and req_c0 are latched into internal registers.
  - err_code is cleared.
  - The FSM moves to WR_MODE on the next edge.
- Bus rule:
  - Every bus state holds address, data and strobe stable while mgmt_waitrequest=1.
  - A transfer completes on the edge where the strobe is high and waitrequest=0.
  - Strobes drop the cycle after completion.
  - mgmt_write and mgmt_read are never both high.
- FSM, in order:
  - IDLE
  - WR_MODE: addr 0x00, data 1 (polling mode)
  - WR_N: addr 0x03, data {14'b0, n}
  - WR_M: addr 0x04, data {14'b0, m}
  - WR_C0: addr 0x05, data {9'b0, 5'd0 counter select in [22:18], c0}
  - WR_START: addr 0x02, data 1
  - POLL_RD: addr 0x01, read
  - POLL_CHK
  - WAIT_LOCK
  - FIN
- POLL_CHK:
  - If readdata[0]=1, go to WAIT_LOCK and clear the timeout counter.
  - Otherwise increment the poll count. If the count equals POLL_LIMIT, go to FIN with err_code=1; else return to POLL_RD.
- WAIT_LOCK:
  - Success: the synchronised locked is 1 for 4 consecutive cycles. This rejects the stale lock present before the PLL relocks.
  - Failure: the cycle counter reaches LOCK_TIMEOUT first, giving err_code=2.
- FIN:
  - Emits a one-cycle done or error pulse, then returns to IDLE.
  - A new request may be accepted the cycle after FIN.
- Request behaviour outside IDLE: req_valid is ignored and no queueing occurs. Input words may change freely after acceptance.
- waitrequest stuck high in a write state: no timeout. The bus protocol owns this; verification checks that the FSM holds.
- Locked glitch in WAIT_LOCK: a drop of the synchronised locked resets the 4-cycle qualifier, not the timeout counter.
- rst_n asserted mid-transaction: the FSM aborts immediately and strobes drop asynchronously. The reconfig core is not otherwise cleaned up; the host must reissue.
- Latency with zero waitrequest and first poll done: accept → done pulse = 6 writes/read at 2 cycles each + POLL_CHK + lock qualification (≥4 + SYNC_STAGES) + FIN.

Decomposition:
- Package pll_reconfig_pkg holds:
  - the state enum
  - address constants ADDR_MODE=0, ADDR_STATUS=1, ADDR_START=2, ADDR_N=3, ADDR_M=4, ADDR_C=5
  - err_code constants
  - the counter-word field offsets
- One sub-module, pll_lock_sync: SYNC_STAGES flop chain plus the 4-cycle stable qualifier. It outputs lock_stable.

Test Plan:
- Nominal, zero waitrequest, status done on first read, locked rises 10 cycles after start:
  - Stimulus: n=0x10000, m=0x00A0A, c0=0x00505.
  - Required response: writes appear in order (0x00,1), (0x03,0x10000), (0x04,0x00A0A), (0x05,0x00505), (0x02,1), followed by one read of 0x01. A single done pulse follows, with err_code=0.
- waitrequest held 3 cycles on each write → address, data and write stay stable all 3 cycles; write sequence unchanged; done asserted.
- POLL_LIMIT=4, status bit0 always 0 → exactly 4 reads at 0x01, error pulse, err_code=1, busy low the cycle after.
- LOCK_TIMEOUT=50, locked stays low → error pulse exactly 50 cycles after entering WAIT_LOCK, err_code=2.
- locked pulses high 3 cycles, drops, then stays high → no done until 4 stable cycles after the second rise.
- rst_n low during WR_M → all strobes 0 immediately, req_ready=1 after release, a new request completes normally; req_valid during busy is ignored, so there is only one done per accepted request.
